// File: rtl/soc_pkg.sv
// Shared soc_if definitions: bus widths, initiator FSM states, command/response records.
package soc_pkg;

  localparam int SOC_DW  = 32;
  localparam int SOC_BEW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } bus_init_st_t;

  typedef struct packed {
    logic [31:0]         addr;
    logic [SOC_BEW-1:0]  be;
    logic [SOC_DW-1:0]   wdat;
  } soc_cmd_t;

  typedef struct packed {
    logic [SOC_DW-1:0]   rdat;
    logic                err;
  } soc_rsp_t;

endpackage

// File: rtl/soc_bus_initiator.sv
// soc_if bus master: takes one host command at a time, drives it onto the
// fabric until the slave acks or the watchdog expires, then returns a response.
module soc_bus_initiator
  import soc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                TMO_CYC  = 256,
  parameter logic [SOC_DW-1:0] ERR_RDAT = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                arst,
  // host command stream
  input  logic                cmd_vld,
  output logic                cmd_rdy,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [SOC_BEW-1:0]  cmd_be,
  input  logic [SOC_DW-1:0]   cmd_wdat,
  // host response stream
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [SOC_DW-1:0]   rsp_rdat,
  output logic                rsp_err,
  // soc_if fabric side
  output logic                m_vld,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [SOC_BEW-1:0]  m_we,
  output logic [SOC_DW-1:0]   m_wdat,
  input  logic                m_rdy,
  input  logic [SOC_DW-1:0]   m_rdat
);

  localparam int              TW       = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TMO_CYC - 1);
  // Word alignment: the two byte-offset bits never reach the fabric.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};

  bus_init_st_t        state_q,   state_d;
  logic [TW-1:0]       timer_q,   timer_d;
  logic                cmd_rdy_q, cmd_rdy_d;
  logic                m_vld_q,   m_vld_d;
  logic [ADDR_W-1:0]   m_addr_q,  m_addr_d;
  logic [SOC_BEW-1:0]  m_we_q,    m_we_d;
  logic [SOC_DW-1:0]   m_wdat_q,  m_wdat_d;
  logic                rsp_vld_q, rsp_vld_d;
  soc_rsp_t            rsp_q,     rsp_d;

  // Next-state and datapath decode for the IDLE -> REQ -> RSP transaction.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    timer_d   = timer_q;
    m_vld_d   = m_vld_q;
    m_addr_d  = m_addr_q;
    m_we_d    = m_we_q;
    m_wdat_d  = m_wdat_q;
    rsp_vld_d = rsp_vld_q;
    rsp_d     = rsp_q;

    unique case (state_q)
      IDLE: begin
        // cmd_rdy_q is low for one cycle after reset release; gate on it so
        // the host only ever sees acceptance where cmd_rdy was visible.
        if (cmd_vld && cmd_rdy_q) begin
          m_addr_d = cmd_addr & ADDR_MASK;
          m_we_d   = cmd_be;
          m_wdat_d = cmd_wdat;
          m_vld_d  = 1'b1;
          timer_d  = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        // A slave ack on the final watchdog cycle still counts as completion.
        if (m_rdy) begin
          rsp_d.rdat = (m_we_q == '0) ? m_rdat : '0;
          rsp_d.err  = 1'b0;
          rsp_vld_d  = 1'b1;
          m_vld_d    = 1'b0;
          m_we_d     = '0;
          state_d    = RSP;
        end else if (timer_q == TMO_LAST) begin
          rsp_d.rdat = ERR_RDAT;
          rsp_d.err  = 1'b1;
          rsp_vld_d  = 1'b1;
          m_vld_d    = 1'b0;
          m_we_d     = '0;
          state_d    = RSP;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      RSP: begin
        if (rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so cmd_rdy drops on the very edge that accepts a command.
    cmd_rdy_d = (state_d == IDLE);
  end

  // State and output registers; reset clears everything so m_vld drops at once.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      cmd_rdy_q <= 1'b0;
      m_vld_q   <= 1'b0;
      m_addr_q  <= '0;
      m_we_q    <= '0;
      m_wdat_q  <= '0;
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      timer_q   <= timer_d;
      cmd_rdy_q <= cmd_rdy_d;
      m_vld_q   <= m_vld_d;
      m_addr_q  <= m_addr_d;
      m_we_q    <= m_we_d;
      m_wdat_q  <= m_wdat_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_q     <= rsp_d;
    end
  end

  assign cmd_rdy  = cmd_rdy_q;
  assign m_vld    = m_vld_q;
  assign m_addr   = m_addr_q;
  assign m_we     = m_we_q;
  assign m_wdat   = m_wdat_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_rdat = rsp_q.rdat;
  assign rsp_err  = rsp_q.err;

endmodule

// File: tb/tb_soc_bus_initiator.sv
// Self-checking bench for soc_bus_initiator: directed scenarios plus random
// transactions, each checked against a transaction-level expectation.
module tb_soc_bus_initiator;

  localparam int          TMO  = 8;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        arst;
  logic        cmd_vld, cmd_rdy;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdat;
  logic        rsp_vld, rsp_rdy;
  logic [31:0] rsp_rdat;
  logic        rsp_err;
  logic        m_vld;
  logic [31:0] m_addr;
  logic [3:0]  m_we;
  logic [31:0] m_wdat;
  logic        m_rdy;
  logic [31:0] m_rdat;

  int n_total = 0;
  int n_bad   = 0;

  soc_bus_initiator #(
    .ADDR_W   (32),
    .TMO_CYC  (TMO),
    .ERR_RDAT (ERRV)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_addr (cmd_addr),
    .cmd_be   (cmd_be),
    .cmd_wdat (cmd_wdat),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_rdat (rsp_rdat),
    .rsp_err  (rsp_err),
    .m_vld    (m_vld),
    .m_addr   (m_addr),
    .m_we     (m_we),
    .m_wdat   (m_wdat),
    .m_rdy    (m_rdy),
    .m_rdat   (m_rdat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One host transaction. dly = cycles the slave waits after m_vld rises
  // before acking (dly >= TMO means it never acks in time).
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdat, input int dly,
                         input logic [31:0] sdat, input int stall,
                         input bit late_rdy);
    int          n_vld;
    int          guard;
    bit          exp_err;
    int          exp_vld;
    logic [31:0] exp_rdat;
    logic [31:0] exp_addr;

    exp_err  = (dly >= TMO);
    exp_vld  = exp_err ? TMO : dly + 1;
    exp_rdat = exp_err ? ERRV : ((be == 4'h0) ? sdat : 32'h0);
    exp_addr = {addr[31:2], 2'b00};

    guard = 0;
    while (!cmd_rdy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_rdy_idle", cmd_rdy, 1);

    cmd_vld  = 1'b1;
    cmd_addr = addr;
    cmd_be   = be;
    cmd_wdat = wdat;
    @(negedge clk);
    // Scramble command inputs: the bus request must come from captured values.
    cmd_vld  = 1'b0;
    cmd_addr = $urandom;
    cmd_be   = 4'($urandom);
    cmd_wdat = $urandom;
    check("m_vld_latency", m_vld, 1);

    n_vld = 0;
    while (m_vld && n_vld < 40) begin
      n_vld++;
      check("m_addr", m_addr, exp_addr);
      check("m_we",   m_we,   be);
      check("m_wdat", m_wdat, wdat);
      check("cmd_rdy_busy", cmd_rdy, 0);
      m_rdy  = (n_vld == dly + 1);
      m_rdat = m_rdy ? sdat : $urandom;
      @(negedge clk);
    end
    m_rdy = 1'b0;
    check("vld_cycles", n_vld, exp_vld);
    check("m_we_off",   m_we, 0);
    check("rsp_vld",    rsp_vld, 1);
    check("rsp_rdat",   rsp_rdat, exp_rdat);
    check("rsp_err",    rsp_err, exp_err);

    for (int i = 0; i < stall; i++) begin
      rsp_rdy  = 1'b0;
      m_rdy    = late_rdy;
      m_rdat   = $urandom;
      cmd_vld  = 1'b1;
      @(negedge clk);
      check("stall_rsp_vld",  rsp_vld, 1);
      check("stall_rsp_rdat", rsp_rdat, exp_rdat);
      check("stall_rsp_err",  rsp_err, exp_err);
      check("stall_cmd_rdy",  cmd_rdy, 0);
      check("stall_m_vld",    m_vld, 0);
    end
    cmd_vld = 1'b0;
    m_rdy   = 1'b0;
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    check("rsp_vld_done", rsp_vld, 0);
    check("cmd_rdy_back", cmd_rdy, 1);

    if (late_rdy) begin
      // Stray slave ack while idle must not start or complete anything.
      m_rdy = 1'b1;
      @(negedge clk);
      m_rdy = 1'b0;
      check("stray_m_vld",   m_vld, 0);
      check("stray_rsp_vld", rsp_vld, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    arst     = 1'b1;
    cmd_vld  = 1'b0;
    cmd_addr = '0;
    cmd_be   = '0;
    cmd_wdat = '0;
    rsp_rdy  = 1'b0;
    m_rdy    = 1'b0;
    m_rdat   = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_rdy",  cmd_rdy, 0);
    check("rst_rsp_vld",  rsp_vld, 0);
    check("rst_rsp_err",  rsp_err, 0);
    check("rst_rsp_rdat", rsp_rdat, 0);
    check("rst_m_vld",    m_vld, 0);
    check("rst_m_we",     m_we, 0);
    check("rst_m_addr",   m_addr, 0);
    check("rst_m_wdat",   m_wdat, 0);
    arst = 1'b0;
    @(negedge clk);

    // Directed scenarios.
    run_txn(32'h0000_0010, 4'hF, 32'hA5A5_1234, 1,       32'h1111_2222, 0,  0); // write
    run_txn(32'h0000_0013, 4'h0, 32'h0,         5,       32'hCAFE_0001, 0,  0); // read
    run_txn(32'h0000_0020, 4'h0, 32'h0,         100,     32'h5555_AAAA, 3,  1); // timeout + late rdy
    run_txn(32'h0000_0024, 4'h3, 32'h7777_8888, 100,     32'h0,         0,  0); // write timeout
    run_txn(32'h0000_0030, 4'h0, 32'h0,         TMO - 1, 32'h1234_5678, 0,  0); // ack on timeout cycle
    run_txn(32'h0000_0040, 4'h0, 32'h0,         0,       32'h0BAD_F00D, 10, 0); // back-pressure
    run_txn(32'h0000_0044, 4'h5, 32'h0F0F_0F0F, 2,       32'h0,         0,  0); // next after release

    // Reset while a read sits in REQ.
    cmd_vld  = 1'b1;
    cmd_addr = 32'h0000_0050;
    cmd_be   = 4'h0;
    @(negedge clk);
    cmd_vld = 1'b0;
    check("pre_rst_m_vld", m_vld, 1);
    repeat (2) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    check("midrst_m_vld",   m_vld, 0);
    check("midrst_rsp_vld", rsp_vld, 0);
    check("midrst_cmd_rdy", cmd_rdy, 0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check("postrst_cmd_rdy", cmd_rdy, 1);
    run_txn(32'h0000_0054, 4'h0, 32'h0, 3, 32'hFEED_0042, 0, 0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      logic [3:0] be;
      be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      run_txn($urandom, be, $urandom, $urandom_range(0, TMO + 3), $urandom,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
